// File: rtl/bist_ctrl.sv
// BIST sequencer: Galois LFSR pattern source, MISR response compactor, golden compare.
// Optional feature macro: BIST_CTRL_ABORT_EN (adds ABORT input to cancel a run).

module bist_ctrl #(
    parameter int                W      = 8,
    parameter longint unsigned   N_PAT  = 255,
    parameter int                LAT    = 1,
    parameter logic [W-1:0]      SEED   = 'h01,
    parameter logic [W-1:0]      TAPS   = 'hB8,
    parameter logic [W-1:0]      GOLDEN = 'h00
) (
    input  logic         CK,
    input  logic         RST,
    input  logic         START,
`ifdef BIST_CTRL_ABORT_EN
    input  logic         ABORT,
`endif
    input  logic [W-1:0] RESP,
    output logic [W-1:0] PAT,
    output logic         BUSY,
    output logic         DONE,
    output logic         PASS,
    output logic [W-1:0] SIG
);

    // state | meaning
    // IDLE  | waiting for START, outputs quiet
    // APPLY | driving one LFSR pattern per cycle
    // DRAIN | waiting LAT cycles for the last responses
    // FIN   | signature final, DONE/PASS valid until next START
    typedef enum logic [1:0] {IDLE, APPLY, DRAIN, FIN} state_t;

    localparam int CW = $clog2(N_PAT + 1);
    localparam int LW = (LAT > 0) ? LAT : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N_PAT - 1);

    state_t        state;
    logic [W-1:0]  lfsr;
    logic [W-1:0]  misr;
    logic [W-1:0]  lfsr_nxt;
    logic [W-1:0]  misr_nxt;
    logic [W-1:0]  misr_fin;
    logic [CW-1:0] cnt;
    logic [2:0]    dcnt;
    logic [LW-1:0] vld_q;
    logic          rsp_vld;
    logic          abort_hit;

`ifdef BIST_CTRL_ABORT_EN
    assign abort_hit = ABORT && BUSY;
`else
    assign abort_hit = 1'b0;
`endif

    // With LAT=0 the response belongs to the pattern currently in APPLY.
    assign rsp_vld = (LAT == 0) ? (state == APPLY) : vld_q[LW-1];

    always_comb begin
        lfsr_nxt = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
        misr_nxt = {misr[W-2:0], 1'b0} ^ (misr[W-1] ? TAPS : '0) ^ RESP;
        misr_fin = rsp_vld ? misr_nxt : misr;
    end

    assign SIG = misr;

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            lfsr  <= SEED;
            misr  <= '0;
            cnt   <= '0;
            dcnt  <= '0;
            vld_q <= '0;
            PAT   <= '0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
            PASS  <= 1'b0;
        end else if (abort_hit) begin
            // misr is deliberately held so the partial signature stays readable
            state <= IDLE;
            vld_q <= '0;
            PAT   <= '0;
            BUSY  <= 1'b0;
        end else begin
            vld_q <= (vld_q << 1) | LW'(state == APPLY);
            if (rsp_vld)
                misr <= misr_nxt;
            case (state)
                IDLE, FIN: begin
                    if (START) begin
                        state <= APPLY;
                        lfsr  <= SEED;
                        misr  <= '0;
                        cnt   <= '0;
                        vld_q <= '0;
                        PAT   <= SEED;
                        BUSY  <= 1'b1;
                        DONE  <= 1'b0;
                        PASS  <= 1'b0;
                    end
                end
                APPLY: begin
                    lfsr <= lfsr_nxt;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST_CNT) begin
                        PAT <= '0;
                        if (LAT == 0) begin
                            state <= FIN;
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                            PASS  <= (misr_fin == GOLDEN);
                        end else begin
                            state <= DRAIN;
                            dcnt  <= 3'(LAT - 1);
                        end
                    end else begin
                        PAT <= lfsr_nxt;
                    end
                end
                DRAIN: begin
                    if (dcnt == 3'd0) begin
                        state <= FIN;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                        PASS  <= (misr_fin == GOLDEN);
                    end else begin
                        dcnt <= dcnt - 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bist_ctrl.sv
// Randomized self-checking bench for bist_ctrl: LAT=0 and LAT=2 instances side by side,
// compared cycle by cycle against a schedule-based reference model.

module tb_bist_ctrl;

    localparam int          N    = 4;
    localparam logic [7:0]  SEED = 8'h01;
    localparam logic [7:0]  TAPS = 8'hB8;
    localparam logic [7:0]  GOLD = 8'hB6;

    logic       CK = 1'b0;
    logic       RST = 1'b1;
    logic       START = 1'b0;
    logic       ABORT = 1'b0;
    logic [7:0] resp0 = '0, resp2 = '0;
    logic [7:0] pat0, pat2, sig0, sig2;
    logic       busy0, busy2, done0, done2, pass0, pass2;

    int n_chk = 0;
    int n_pass = 0;

    logic [7:0] rtab [2][N];

    always #5 CK = ~CK;

    bist_ctrl #(.W(8), .N_PAT(4), .LAT(0), .SEED(SEED), .TAPS(TAPS), .GOLDEN(GOLD)) u_lat0 (
        .CK(CK), .RST(RST), .START(START),
`ifdef BIST_CTRL_ABORT_EN
        .ABORT(ABORT),
`endif
        .RESP(resp0), .PAT(pat0), .BUSY(busy0), .DONE(done0), .PASS(pass0), .SIG(sig0)
    );

    bist_ctrl #(.W(8), .N_PAT(4), .LAT(2), .SEED(SEED), .TAPS(TAPS), .GOLDEN(GOLD)) u_lat2 (
        .CK(CK), .RST(RST), .START(START),
`ifdef BIST_CTRL_ABORT_EN
        .ABORT(ABORT),
`endif
        .RESP(resp2), .PAT(pat2), .BUSY(busy2), .DONE(done2), .PASS(pass2), .SIG(sig2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    // k-th pattern of the sequence, straight from the LFSR recurrence
    function automatic logic [7:0] lfsr_at(input int k);
        logic [7:0] v = SEED;
        for (int i = 0; i < k; i++) v = (v >> 1) ^ (v[0] ? TAPS : 8'h00);
        return v;
    endfunction

    // signature after compacting the first j responses of a run
    function automatic logic [7:0] sig_of(input int inst, input int j);
        logic [7:0] m = 8'h00;
        for (int i = 0; i < j; i++) m = {m[6:0], 1'b0} ^ (m[7] ? TAPS : 8'h00) ^ rtab[inst][i];
        return m;
    endfunction

    function automatic int clampn(input int v);
        return (v < 0) ? 0 : (v > N) ? N : v;
    endfunction

    // response for pattern k must be on RESP during cycle k+LAT; anything else is noise
    function automatic logic [7:0] resp_for(input int inst, input int lat, input int c);
        int k = c - lat;
        if (k >= 0 && k < N) return rtab[inst][k];
        return 8'($urandom);
    endfunction

    task automatic check_cycle(input int inst, input int lat, input int c,
                               input logic [7:0] pat, input logic busy, input logic done,
                               input logic pass, input logic [7:0] sig);
        logic eb = (c < N + lat);
        logic [7:0] ep = (c < N) ? lfsr_at(c) : 8'h00;
        logic ep_pass = !eb && (sig_of(inst, N) == GOLD);
        chk($sformatf("L%0d c%0d pat", lat, c), 32'(pat), 32'(ep));
        chk($sformatf("L%0d c%0d busy", lat, c), 32'(busy), 32'(eb));
        chk($sformatf("L%0d c%0d done", lat, c), 32'(done), 32'(!eb));
        chk($sformatf("L%0d c%0d pass", lat, c), 32'(pass), 32'(ep_pass));
        chk($sformatf("L%0d c%0d sig", lat, c), 32'(sig), 32'(sig_of(inst, clampn(c - lat))));
    endtask

    task automatic check_quiet(input string tag, input logic [7:0] h0, input logic [7:0] h2);
        chk({tag, " pat0"}, 32'(pat0), 32'h0);
        chk({tag, " busy0"}, 32'(busy0), 32'h0);
        chk({tag, " done0"}, 32'(done0), 32'h0);
        chk({tag, " pass0"}, 32'(pass0), 32'h0);
        chk({tag, " sig0"}, 32'(sig0), 32'(h0));
        chk({tag, " pat2"}, 32'(pat2), 32'h0);
        chk({tag, " busy2"}, 32'(busy2), 32'h0);
        chk({tag, " done2"}, 32'(done2), 32'h0);
        chk({tag, " pass2"}, 32'(pass2), 32'h0);
        chk({tag, " sig2"}, 32'(sig2), 32'(h2));
    endtask

    // mode: 0 loopback, 1 bit0 stuck at 0, 2 random responses
    // twist: 0 plain, 1 extra START at E2, 2 reset after E2, 3 ABORT+START at E2
    task automatic run(input int mode, input int twist);
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < N; k++)
                rtab[i][k] = (mode == 0) ? lfsr_at(k) :
                             (mode == 1) ? (lfsr_at(k) & 8'hFE) : 8'($urandom);
        START = 1'b1;
        resp0 = 8'($urandom);
        resp2 = 8'($urandom);
        @(posedge CK); #1;
        START = 1'b0;
        for (int c = 0; c <= N + 3; c++) begin
            check_cycle(0, 0, c, pat0, busy0, done0, pass0, sig0);
            check_cycle(1, 2, c, pat2, busy2, done2, pass2, sig2);
            if (twist == 2 && c == 2) begin
                RST = 1'b1;
                #1;
                check_quiet("midrst", 8'h00, 8'h00);
                RST = 1'b0;
                return;
            end
            resp0 = resp_for(0, 0, c);
            resp2 = resp_for(1, 2, c);
            START = (twist == 1 && c == 1);
            if (twist == 3 && c == 1) begin
                START = 1'b1;
                ABORT = 1'b1;
                @(posedge CK); #1;
                START = 1'b0;
                ABORT = 1'b0;
                check_quiet("abort", sig_of(0, 1), sig_of(1, 0));
                resp0 = 8'($urandom);
                resp2 = 8'($urandom);
                @(posedge CK); #1;
                check_quiet("abort_idle", sig_of(0, 1), sig_of(1, 0));
                return;
            end
            @(posedge CK); #1;
        end
        START = 1'b0;
    endtask

    initial begin
        #2;
        check_quiet("reset", 8'h00, 8'h00);
        @(negedge CK);
        RST = 1'b0;
        @(posedge CK); #1;
        check_quiet("post_reset", 8'h00, 8'h00);

        run(0, 0);
        run(1, 0);
        run(2, 0);
        run(0, 1);
        run(0, 2);
        run(0, 0);
`ifdef BIST_CTRL_ABORT_EN
        run(0, 3);
        run(0, 0);
`endif
        for (int i = 0; i < 4; i++) run(2, $urandom_range(0, 1));
        run(0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
